fuglevand_mu_pool: RTL

Time-multiplexed bank of NUM_MU Fuglevand twitch filters, one per motor unit, sharing a single IEEE-754 single-precision datapath built from the existing combinational mult/add/sub/int_to_float cores. On each sample tick it updates every unit's second-order twitch state in turn and sums the gain-weighted unit forces into one total force. It is the multi-unit successor to the single-channel twitch muscle and feeds the existing total-force/length-weight stages.

---
 rtl/mu_pool_pkg.sv | 129 ++++++++++++
 rtl/mu_twitch_update.sv | 37 +++
 rtl/fuglevand_mu_pool.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mu_pool_pkg.sv
// Shared definitions for the motor-unit pool: coefficient select encodings, FSM states,
// float constants and the single-precision arithmetic cores (multiply, add, int-to-float).
// All cores are purely combinational, round to nearest even, and flush subnormals to zero.
package mu_pool_pkg;

  localparam logic [1:0] COEF_B1   = 2'd0;
  localparam logic [1:0] COEF_A1   = 2'd1;
  localparam logic [1:0] COEF_A2   = 2'd2;
  localparam logic [1:0] COEF_GAIN = 2'd3;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  // Rounds a normalised 24-bit significand (bit 23 set) and packs it, handling the
  // carry out of rounding as well as exponent overflow and underflow.
  function automatic logic [31:0] fp_round_pack(input logic sign, input logic signed [9:0] exp,
                                                input logic [23:0] mant, input logic guard,
                                                input logic sticky);
    logic [24:0]       m;
    logic signed [9:0] e;
    m = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    e = exp;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {sign, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {sign, 31'd0};
    return {sign, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sign;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       p;
    logic signed [9:0] e;
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
    if (a_inf || b_inf) return {sign, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {sign, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return fp_round_pack(sign, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return fp_round_pack(sign, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [31:0]       hi, lo;
    logic [7:0]        d8;
    logic [26:0]       mh, ml, lost;
    logic [27:0]       s;
    logic signed [9:0] e;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return FP_QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    d8 = hi[30:23] - lo[30:23];
    // Three extra low bits act as guard, round and sticky during alignment.
    mh = {1'b1, hi[22:0], 3'b000};
    ml = {1'b1, lo[22:0], 3'b000};
    if (d8 > 8'd26) begin
      ml = 27'd1;
    end else begin
      lost = ml & ((27'd1 << d8) - 27'd1);
      ml   = (ml >> d8) | {26'd0, |lost};
    end
    e = $signed({2'b00, hi[30:23]});
    if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, ml};
    else                  s = {1'b0, mh} - {1'b0, ml};
    if (s == 28'd0) return FP_ZERO;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26]) begin
          s = {s[26:0], 1'b0};
          e = e - 10'sd1;
        end
      end
    end
    return fp_round_pack(hi[31], e, s[26:3], s[2], s[1] | s[0]);
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    return fp_add(a, {~b[31], b[30:0]});
  endfunction

  function automatic logic [31:0] int_to_float(input logic [31:0] u);
    logic [31:0]       v;
    logic signed [9:0] e;
    if (u == 32'd0) return FP_ZERO;
    v = u;
    e = 10'sd158;  // bias + 31: exponent when the MSB is already at bit 31
    for (int i = 0; i < 31; i++) begin
      if (!v[31]) begin
        v = {v[30:0], 1'b0};
        e = e - 10'sd1;
      end
    end
    return fp_round_pack(1'b0, e, v[31:8], v[7], |v[6:0]);
  endfunction

endpackage

// File: rtl/mu_twitch_update.sv
// Combinational second-order twitch update for one motor unit.
//   x_cur_i        current input sample (float), becomes the next x1
//   x1_i/y1_i/y2_i unit state
//   b1_i/a1_i/a2_i filter coefficients (a1 = -2a, a2 = a^2), gain_i unit gain
//   x_next_o       next x1 value
//   y_new_o        b1*x1 - (a1*y1 + a2*y2)
//   gy_o           gain * y_new
module mu_twitch_update
  import mu_pool_pkg::*;
(
  input  logic [31:0] x_cur_i,
  input  logic [31:0] x1_i,
  input  logic [31:0] y1_i,
  input  logic [31:0] y2_i,
  input  logic [31:0] b1_i,
  input  logic [31:0] a1_i,
  input  logic [31:0] a2_i,
  input  logic [31:0] gain_i,
  output logic [31:0] x_next_o,
  output logic [31:0] y_new_o,
  output logic [31:0] gy_o
);

  logic [31:0] ff_term, fb1_term, fb2_term, fb_sum;

  always_comb begin
    ff_term  = fp_mul(b1_i, x1_i);
    fb1_term = fp_mul(a1_i, y1_i);
    fb2_term = fp_mul(a2_i, y2_i);
    fb_sum   = fp_add(fb1_term, fb2_term);
    y_new_o  = fp_sub(ff_term, fb_sum);
    gy_o     = fp_mul(gain_i, y_new_o);
    // b2 is fixed at zero, so the current sample only feeds the state.
    x_next_o = x_cur_i;
  end

endmodule

// File: rtl/fuglevand_mu_pool.sv
// Time-multiplexed bank of NUM_MU Fuglevand twitch filters sharing one float datapath.
// A tick snapshots the spike counts, then one unit is updated per cycle and the
// gain-weighted outputs are summed into total_force_out.
//   clk, reset (async, active-low), tick (sample strobe)
//   spike_cnt_bus   unit k counts in bits [32k+31:32k]
//   coef_we/addr/sel/data  coefficient write port (sel: b1, a1, a2, gain)
//   busy            high while units are being processed
//   force_valid     one-cycle pulse when total_force_out updates
//   total_force_out float sum of gain_k*y_k
//   overrun         sticky, tick seen while a pass was in flight
module fuglevand_mu_pool
  import mu_pool_pkg::*;
#(
  parameter int unsigned NUM_MU      = 8,
  parameter int unsigned CH_W        = 3,
  parameter int unsigned SPIKE_SCALE = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [32*NUM_MU-1:0]   spike_cnt_bus,
  input  logic                   coef_we,
  input  logic [CH_W-1:0]        coef_addr,
  input  logic [1:0]             coef_sel,
  input  logic [31:0]            coef_data,
  output logic                   busy,
  output logic                   force_valid,
  output logic [31:0]            total_force_out,
  output logic                   overrun
);

  state_e state_q, state_d;

  logic [CH_W-1:0] ch_q;
  logic [31:0]     spike_snap_q [NUM_MU];
  logic [31:0]     x1_q [NUM_MU];
  logic [31:0]     y1_q [NUM_MU];
  logic [31:0]     y2_q [NUM_MU];
  logic [31:0]     b1_q [NUM_MU];
  logic [31:0]     a1_q [NUM_MU];
  logic [31:0]     a2_q [NUM_MU];
  logic [31:0]     gain_q [NUM_MU];
  logic [31:0]     acc_q, total_q;
  logic            overrun_q;

  logic [31:0] spike_scaled, x_cur, x_next, y_new, gy, acc_next;
  logic        last_ch, coef_hit;

  assign last_ch  = (ch_q == CH_W'(NUM_MU - 1));
  assign coef_hit = coef_we && (32'(coef_addr) < NUM_MU);

  // Unsigned 32-bit scale deliberately wraps modulo 2^32.
  assign spike_scaled = spike_snap_q[ch_q] * 32'(SPIKE_SCALE);
  assign x_cur        = int_to_float(spike_scaled);
  assign acc_next     = fp_add(acc_q, gy);

  mu_twitch_update u_update (
    .x_cur_i  (x_cur),
    .x1_i     (x1_q[ch_q]),
    .y1_i     (y1_q[ch_q]),
    .y2_i     (y2_q[ch_q]),
    .b1_i     (b1_q[ch_q]),
    .a1_i     (a1_q[ch_q]),
    .a2_i     (a2_q[ch_q]),
    .gain_i   (gain_q[ch_q]),
    .x_next_o (x_next),
    .y_new_o  (y_new),
    .gy_o     (gy)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StCalc;
      StCalc:  if (last_ch) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      acc_q     <= FP_ZERO;
      total_q   <= FP_ZERO;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tick && (state_q != StIdle)) overrun_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            acc_q <= FP_ZERO;
            ch_q  <= '0;
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          if (last_ch) begin
            ch_q    <= '0;
            // Published on entry to DONE so it is valid alongside force_valid.
            total_q <= acc_next;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_MU; k++) begin
        spike_snap_q[k] <= 32'd0;
        x1_q[k]         <= FP_ZERO;
        y1_q[k]         <= FP_ZERO;
        y2_q[k]         <= FP_ZERO;
      end
    end else begin
      if ((state_q == StIdle) && tick) begin
        for (int k = 0; k < NUM_MU; k++) spike_snap_q[k] <= spike_cnt_bus[32*k +: 32];
      end
      if (state_q == StCalc) begin
        x1_q[ch_q] <= x_next;
        y2_q[ch_q] <= y1_q[ch_q];
        y1_q[ch_q] <= y_new;
      end
    end
  end

  // Writes land at the edge, so the unit being computed this cycle still sees old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_MU; k++) begin
        b1_q[k]   <= FP_ZERO;
        a1_q[k]   <= FP_ZERO;
        a2_q[k]   <= FP_ZERO;
        gain_q[k] <= FP_ONE;
      end
    end else if (coef_hit) begin
      unique case (coef_sel)
        COEF_B1:   b1_q[coef_addr]   <= coef_data;
        COEF_A1:   a1_q[coef_addr]   <= coef_data;
        COEF_A2:   a2_q[coef_addr]   <= coef_data;
        COEF_GAIN: gain_q[coef_addr] <= coef_data;
        default: ;
      endcase
    end
  end

  assign busy            = (state_q == StCalc);
  assign force_valid     = (state_q == StDone);
  assign total_force_out = total_q;
  assign overrun         = overrun_q;

endmodule
